operand_encoder: RTL and testbench
==================================

Name: operand_encoder

Overview:
- Inverse of the operand decode stage: takes one already-decoded operand description (r/m operand, reg field, displacement, immediate).
- Emits the x86-64 operand byte stream that follows the opcode: ModRM, SIB, disp, imm, LSB first, one byte per cycle over a valid/ready handshake.
- Also produces the REX byte the opcode emitter prepends.
- Sits between the micro-op/rewrite stage and the instruction byte buffer.

Parameters:
- DISP_W, 32, displacement input width (signed).
- IMM_W, 64, immediate input width.
- LEN_W, 4, width of byte-count output.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept a request.
- in_mode  in  2  0=NONE (imm only), 1=MODRM, 2=REL32 (Jz), 3=REL8 (Jb).
- in_rex_w  in  1  REX.W request.
- in_reg  in  4  ModRM.reg source (register id or /digit).
- in_rm_is_reg  in  1  r/m is a register (mod=11).
- in_rip  in  1  r/m is RIP-relative.
- in_has_base  in  1  memory base present.
- in_base  in  4  base register id.
- in_has_index  in  1  index present.
- in_index  in  4  index register id.
- in_scale  in  2  log2 scale.
- in_has_disp  in  1  displacement explicitly present.
- in_disp  in  DISP_W  signed displacement.
- in_imm  in  IMM_W  immediate.
- in_imm_bytes  in  4  immediate length: 0, 1, 2, 4 or 8.
- out_valid  out  1  out_byte valid.
- out_ready  in  1  sink accepts byte.
- out_byte  out  8  stream byte.
- out_last  out  1  final byte of request.
- rex_out  out  8  {4'b0100, W, R, X, B}, latched at accept.
- rex_needed  out  1  any of W/R/X/B set.
- done  out  1  one-cycle pulse at request completion.
- done_len  out  LEN_W  bytes emitted for the completed request.
- err  out  1  one-cycle pulse; request rejected.

Behaviour:
- **Reset:** async on reset_n low. State IDLE. in_ready=1; out_valid, out_last, done, err = 0; rex_out=8'h40; rex_needed=0; done_len=0. Reset mid-stream aborts the request with no done.
- **States:** IDLE, MODRM, SIB, DISP, IMM, FIN.
  - in_ready=1 only in IDLE. Accept on in_valid & in_ready; all fields are registered and the encoding is computed at accept.
  - A state with zero bytes is skipped. The first byte is valid the cycle after accept.
- **Output handshake:** out_byte and out_last stay stable while out_valid & !out_ready. A byte advances only on out_valid & out_ready.
- **Completion:** after the last handshake go to FIN, pulse done with done_len, return to IDLE. A new accept is possible the cycle after FIN.
- **Zero-byte request** (NONE, imm_bytes=0): accept, then FIN, done with done_len=0. No out_valid.
- **MODRM mode:**
  - REX.R = in_reg[3].
  - rm_is_reg: mod=11, rm=base[2:0], REX.B=base[3].
  - rip: mod=00, rm=101, disp32 always.
  - SIB needed if has_index, or !has_base, or base[2:0]=100. Then rm=100 and SIB = {scale, idx, base}:
    - idx = index[2:0], or 100 if no index;
    - SIB base = 101 when !has_base (forces mod=00 + disp32);
    - REX.X = index[3], REX.B = base[3].
  - mod selection with a base present:
    - mod=00 if !has_disp, disp==0, and base[2:0]!=101;
    - else mod=01 + disp8 if disp fits in int8;
    - else mod=10 + disp32.
  - base rbp/r13 with no disp yields mod=01, disp8=00.
- **REL32 / REL8:** no ModRM; disp32 or disp8 only. REL8 with disp outside [-128, 127] is an error.
- **Immediate:** in_imm_bytes LSBs of in_imm, little endian, after any disp.
- **err (no bytes, no done, back to IDLE next cycle):**
  - index id 4'b0100 (rsp);
  - in_imm_bytes not in {0, 1, 2, 4, 8};
  - in_rip with rm_is_reg;
  - REL8 out of range.
- **Limit:** max total 1 + 1 + 4 + 8 = 14 bytes; fits LEN_W=4.

Optional Feature:
- Macro: OPD_ENC_SHORT_DISP_EN.
- Defined: disp8 compression as specified above.
- Undefined: any base-relative disp that is non-zero, or explicit, or has base[2:0]=101 uses mod=10 + disp32. The mod=00 no-disp case is unchanged.
- REL8 is unaffected by the macro.

Test Plan:
- MODRM, rm_is_reg, base=rcx(1), reg=rax(0), imm_bytes=0, out_ready=1 -> single byte C1 with last; rex_out=40, rex_needed=0; done_len=1.
- [rsp+8], reg=r9(9) -> bytes 4C 24 08; rex_out=44, rex_needed=1; done_len=3. Without the macro: 8C 24 08 00 00 00.
- [rbx+rsi*4+0x12345678], reg=rdx, imm_bytes=1, imm=7F -> bytes 94 B3 78 56 34 12 7F; done_len=7. Toggle out_ready 1/0 each cycle: bytes unchanged and none dropped.
- [rbp], no disp, reg=rax -> bytes 45 00. RIP-relative disp=-16 -> bytes 05 F0 FF FF FF.
- Error paths -> err pulse, no out_valid, next request accepted:
  - index=rsp(4);
  - REL8 disp=200;
  - imm_bytes=3.
- reset_n low after the 2nd byte of the 7-byte case -> out_valid=0, in_ready=1, no done; the following request encodes correctly.

Source files
------------

// File: rtl/operand_encoder_if.sv
// operand_encoder_if: request fields, output byte stream and status of operand_encoder.
// slave = encoder side, master = requester / byte sink side.
interface operand_encoder_if #(
    parameter int unsigned DISP_W = 32,
    parameter int unsigned IMM_W  = 64,
    parameter int unsigned LEN_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_mode;
    logic              in_rex_w;
    logic [3:0]        in_reg;
    logic              in_rm_is_reg;
    logic              in_rip;
    logic              in_has_base;
    logic [3:0]        in_base;
    logic              in_has_index;
    logic [3:0]        in_index;
    logic [1:0]        in_scale;
    logic              in_has_disp;
    logic [DISP_W-1:0] in_disp;
    logic [IMM_W-1:0]  in_imm;
    logic [3:0]        in_imm_bytes;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_byte;
    logic              out_last;
    logic [7:0]        rex_out;
    logic              rex_needed;
    logic              done;
    logic [LEN_W-1:0]  done_len;
    logic              err;

    modport slave (
        input  in_valid, in_mode, in_rex_w, in_reg, in_rm_is_reg, in_rip,
               in_has_base, in_base, in_has_index, in_index, in_scale,
               in_has_disp, in_disp, in_imm, in_imm_bytes, out_ready,
        output in_ready, out_valid, out_byte, out_last, rex_out, rex_needed,
               done, done_len, err
    );

    modport master (
        output in_valid, in_mode, in_rex_w, in_reg, in_rm_is_reg, in_rip,
               in_has_base, in_base, in_has_index, in_index, in_scale,
               in_has_disp, in_disp, in_imm, in_imm_bytes, out_ready,
        input  in_ready, out_valid, out_byte, out_last, rex_out, rex_needed,
               done, done_len, err
    );
endinterface

// File: rtl/operand_encoder.sv
// operand_encoder: turns one decoded operand into the x86-64 ModRM/SIB/disp/imm
// byte stream (LSB first, one byte per handshake) and the REX prefix byte.
// Optional feature macro: OPD_ENC_SHORT_DISP_EN enables disp8 compression of
// base-relative displacements; without it they use mod=10 + disp32.
module operand_encoder #(
    parameter int unsigned DISP_W = 32,
    parameter int unsigned IMM_W  = 64,
    parameter int unsigned LEN_W  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    operand_encoder_if.slave bus
);
    localparam logic [1:0] MODE_MODRM = 2'd1;
    localparam logic [1:0] MODE_REL32 = 2'd2;
    localparam logic [1:0] MODE_REL8  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_MODRM, S_SIB, S_DISP, S_IMM, S_FIN} state_t;

    typedef struct packed {
        logic             has_modrm;
        logic             has_sib;
        logic [7:0]       modrm;
        logic [7:0]       sib;
        logic [31:0]      disp;
        logic [2:0]       disp_n;
        logic [IMM_W-1:0] imm;
        logic [3:0]       imm_n;
        logic [LEN_W-1:0] total;
    } enc_t;

    // First non-empty segment after s (S_FIN when nothing is left).
    function automatic state_t seg_after(input state_t s, input enc_t e);
        state_t n;
        n = S_FIN;
        if (s == S_IDLE && e.has_modrm)                                        n = S_MODRM;
        else if ((s == S_IDLE || s == S_MODRM) && e.has_sib)                   n = S_SIB;
        else if ((s == S_IDLE || s == S_MODRM || s == S_SIB) && e.disp_n != 3'd0) n = S_DISP;
        else if (s != S_IMM && s != S_FIN && e.imm_n != 4'd0)                 n = S_IMM;
        return n;
    endfunction

    // Byte count of a segment.
    function automatic logic [3:0] seg_len(input state_t s, input enc_t e);
        case (s)
            S_MODRM, S_SIB: return 4'd1;
            S_DISP:         return {1'b0, e.disp_n};
            S_IMM:          return e.imm_n;
            default:        return 4'd0;
        endcase
    endfunction

    // Byte idx of a segment.
    function automatic logic [7:0] byte_of(input state_t s, input logic [2:0] idx, input enc_t e);
        case (s)
            S_MODRM: return e.modrm;
            S_SIB:   return e.sib;
            S_DISP:  return e.disp[{idx[1:0], 3'b000} +: 8];
            S_IMM:   return e.imm[{idx, 3'b000} +: 8];
            default: return 8'h00;
        endcase
    endfunction

    state_t           r_state;
    logic [2:0]       r_idx;
    enc_t             r_enc;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [7:0]       r_out_byte;
    logic             r_out_last;
    logic [7:0]       r_rex_out;
    logic             r_rex_needed;
    logic             r_done;
    logic [LEN_W-1:0] r_done_len;
    logic             r_err;

    enc_t             w_enc;
    logic             w_err;
    logic             w_fits8;
    logic             w_disp_small;
    logic             w_need_sib;
    logic [1:0]       w_mod;
    logic [2:0]       w_rm;
    logic             w_rex_r;
    logic             w_rex_x;
    logic             w_rex_b;
    logic [7:0]       w_rex;
    enc_t             w_src;
    logic             w_adv_in_seg;
    state_t           w_nstate;
    logic [2:0]       w_nidx;
    logic [7:0]       w_nbyte;
    logic             w_nlast;

    assign w_fits8 = (&bus.in_disp[DISP_W-1:7]) | ~(|bus.in_disp[DISP_W-1:7]);

    // Encode the request currently on the bus (used at accept).
    always_comb begin
        w_enc        = '0;
        w_err        = 1'b0;
        w_mod        = 2'b00;
        w_rm         = 3'b000;
        w_rex_r      = 1'b0;
        w_rex_x      = 1'b0;
        w_rex_b      = 1'b0;
        w_need_sib   = bus.in_has_index || !bus.in_has_base || (bus.in_base[2:0] == 3'b100);
        w_disp_small = !bus.in_has_disp && (bus.in_disp == '0) && (bus.in_base[2:0] != 3'b101);
        w_enc.disp   = bus.in_disp[31:0];
        w_enc.imm    = bus.in_imm;
        w_enc.imm_n  = bus.in_imm_bytes;
        case (bus.in_mode)
            MODE_MODRM: begin
                w_enc.has_modrm = 1'b1;
                w_rex_r         = bus.in_reg[3];
                if (bus.in_rm_is_reg) begin
                    w_mod   = 2'b11;
                    w_rm    = bus.in_base[2:0];
                    w_rex_b = bus.in_base[3];
                    w_err   = bus.in_rip;
                end else if (bus.in_rip) begin
                    w_mod        = 2'b00;
                    w_rm         = 3'b101;
                    w_enc.disp_n = 3'd4;
                end else begin
                    w_err = bus.in_has_index && (bus.in_index == 4'd4);
                    if (!bus.in_has_base) begin
                        w_mod        = 2'b00;
                        w_enc.disp_n = 3'd4;
                    end else if (w_disp_small) begin
                        w_mod        = 2'b00;
                        w_enc.disp_n = 3'd0;
`ifdef OPD_ENC_SHORT_DISP_EN
                    end else if (w_fits8) begin
                        w_mod        = 2'b01;
                        w_enc.disp_n = 3'd1;
`endif
                    end else begin
                        w_mod        = 2'b10;
                        w_enc.disp_n = 3'd4;
                    end
                    if (w_need_sib) begin
                        w_rm          = 3'b100;
                        w_enc.has_sib = 1'b1;
                        w_enc.sib     = {bus.in_scale,
                                         bus.in_has_index ? bus.in_index[2:0] : 3'b100,
                                         bus.in_has_base  ? bus.in_base[2:0]  : 3'b101};
                        w_rex_x       = bus.in_has_index & bus.in_index[3];
                    end else begin
                        w_rm = bus.in_base[2:0];
                    end
                    w_rex_b = bus.in_has_base & bus.in_base[3];
                end
                w_enc.modrm = {w_mod, bus.in_reg[2:0], w_rm};
            end
            MODE_REL32: w_enc.disp_n = 3'd4;
            MODE_REL8: begin
                w_enc.disp_n = 3'd1;
                w_err        = !w_fits8;
            end
            default: ;
        endcase
        case (bus.in_imm_bytes)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd8: ;
            default: w_err = 1'b1;
        endcase
        w_enc.total = LEN_W'(w_enc.has_modrm) + LEN_W'(w_enc.has_sib)
                    + LEN_W'(w_enc.disp_n) + LEN_W'(w_enc.imm_n);
        w_rex = {4'b0100, bus.in_rex_w, w_rex_r, w_rex_x, w_rex_b};
    end

    // Position, value and last flag of the byte that follows the current one.
    always_comb begin
        w_src        = (r_state == S_IDLE) ? w_enc : r_enc;
        w_adv_in_seg = (r_state != S_IDLE) && (({1'b0, r_idx} + 4'd1) < seg_len(r_state, w_src));
        w_nstate     = w_adv_in_seg ? r_state : seg_after(r_state, w_src);
        w_nidx       = w_adv_in_seg ? (r_idx + 3'd1) : 3'd0;
        w_nbyte      = byte_of(w_nstate, w_nidx, w_src);
        w_nlast      = ({1'b0, w_nidx} == (seg_len(w_nstate, w_src) - 4'd1))
                    && (seg_after(w_nstate, w_src) == S_FIN);
    end

    // Control FSM with registered stream and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_idx        <= 3'd0;
            r_enc        <= '0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_byte   <= 8'h00;
            r_out_last   <= 1'b0;
            r_rex_out    <= 8'h40;
            r_rex_needed <= 1'b0;
            r_done       <= 1'b0;
            r_done_len   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_rex_out    <= w_rex;
                        r_rex_needed <= |w_rex[3:0];
                        if (w_err) begin
                            r_err <= 1'b1;
                        end else begin
                            r_enc      <= w_enc;
                            r_in_ready <= 1'b0;
                            r_state    <= w_nstate;
                            r_idx      <= w_nidx;
                            if (w_nstate == S_FIN) begin
                                r_done     <= 1'b1;
                                r_done_len <= w_enc.total;
                            end else begin
                                r_out_valid <= 1'b1;
                                r_out_byte  <= w_nbyte;
                                r_out_last  <= w_nlast;
                            end
                        end
                    end
                end
                S_MODRM, S_SIB, S_DISP, S_IMM: begin
                    if (bus.out_ready) begin
                        r_state <= w_nstate;
                        r_idx   <= w_nidx;
                        if (w_nstate == S_FIN) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_done      <= 1'b1;
                            r_done_len  <= r_enc.total;
                        end else begin
                            r_out_byte <= w_nbyte;
                            r_out_last <= w_nlast;
                        end
                    end
                end
                S_FIN: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_byte   = r_out_byte;
    assign bus.out_last   = r_out_last;
    assign bus.rex_out    = r_rex_out;
    assign bus.rex_needed = r_rex_needed;
    assign bus.done       = r_done;
    assign bus.done_len   = r_done_len;
    assign bus.err        = r_err;
endmodule

// File: tb/tb_operand_encoder.sv
// tb_operand_encoder: scoreboard bench for operand_encoder; expected bytes are
// queued when a request is driven and popped as the encoder emits them.
module tb_operand_encoder;
    localparam int unsigned DISP_W = 32;
    localparam int unsigned IMM_W  = 64;
    localparam int unsigned LEN_W  = 4;

    logic clk;
    logic reset_n;
    logic toggle_en;
    int   n_vec;
    int   n_bad;
    logic [8:0] exp_q[$];
    logic       hold_pend;
    logic [8:0] hold_val;

    operand_encoder_if #(.DISP_W(DISP_W), .IMM_W(IMM_W), .LEN_W(LEN_W)) bus_if ();

    operand_encoder #(.DISP_W(DISP_W), .IMM_W(IMM_W), .LEN_W(LEN_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sink side: out_ready toggles every cycle when toggle_en, else held high.
    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) bus_if.out_ready = ~bus_if.out_ready;
            else           bus_if.out_ready = 1'b1;
        end
    end

    // Output monitor: pops the scoreboard on each handshake, checks stalls hold.
    always @(negedge clk) begin
        logic [8:0] e;
        if (!reset_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend && bus_if.out_valid)
                check("hold_byte", 64'({bus_if.out_last, bus_if.out_byte}), 64'(hold_val));
            hold_pend = 1'b0;
            if (bus_if.out_valid && bus_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte_valid", 64'(bus_if.out_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 64'(bus_if.out_byte), 64'(e[7:0]));
                    check("last", 64'(bus_if.out_last), 64'(e[8]));
                end
            end else if (bus_if.out_valid) begin
                hold_pend = 1'b1;
                hold_val  = {bus_if.out_last, bus_if.out_byte};
            end
        end
    end

    task automatic req(input logic [1:0] mode, input logic rex_w, input logic [3:0] rg,
                       input logic rm_is_reg, input logic rip,
                       input logic has_base, input logic [3:0] base,
                       input logic has_index, input logic [3:0] index, input logic [1:0] scale,
                       input logic has_disp, input logic [31:0] disp,
                       input logic [63:0] imm, input logic [3:0] imm_bytes);
        bus_if.in_mode      = mode;
        bus_if.in_rex_w     = rex_w;
        bus_if.in_reg       = rg;
        bus_if.in_rm_is_reg = rm_is_reg;
        bus_if.in_rip       = rip;
        bus_if.in_has_base  = has_base;
        bus_if.in_base      = base;
        bus_if.in_has_index = has_index;
        bus_if.in_index     = index;
        bus_if.in_scale     = scale;
        bus_if.in_has_disp  = has_disp;
        bus_if.in_disp      = disp;
        bus_if.in_imm       = imm;
        bus_if.in_imm_bytes = imm_bytes;
    endtask

    // Queue n expected bytes, v holds them least significant byte first.
    task automatic expect_bytes(input int n, input logic [111:0] v);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(i == n - 1), v[i*8 +: 8]});
    endtask

    task automatic accept(input string tag);
        bit ok;
        ok = 1'b0;
        bus_if.in_valid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (bus_if.in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus_if.in_valid = 1'b0;
        check({tag, "_accept"}, 64'(ok), 64'd1);
    endtask

    task automatic fire(input string tag, input logic exp_err, input logic [7:0] exp_rex, input int exp_len);
        bit ok;
        accept(tag);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (bus_if.done || bus_if.err) ok = 1'b1;
        end
        check({tag, "_complete"}, 64'(ok), 64'd1);
        check({tag, "_err"}, 64'(bus_if.err), 64'(exp_err));
        check({tag, "_done"}, 64'(bus_if.done), 64'(!exp_err));
        check({tag, "_out_valid"}, 64'(bus_if.out_valid), 64'd0);
        if (!exp_err) begin
            check({tag, "_done_len"}, 64'(bus_if.done_len), 64'(exp_len));
            check({tag, "_rex"}, 64'(bus_if.rex_out), 64'(exp_rex));
            check({tag, "_rex_needed"}, 64'(bus_if.rex_needed), 64'(|exp_rex[3:0]));
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        n_vec = 0;
        n_bad = 0;
        toggle_en = 1'b0;
        hold_pend = 1'b0;
        bus_if.in_valid = 1'b0;
        req(2'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 2'd0, 0, 32'd0, 64'd0, 4'd0);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",   64'(bus_if.in_ready),   64'd1);
        check("rst_out_valid",  64'(bus_if.out_valid),  64'd0);
        check("rst_out_last",   64'(bus_if.out_last),   64'd0);
        check("rst_done",       64'(bus_if.done),       64'd0);
        check("rst_err",        64'(bus_if.err),        64'd0);
        check("rst_rex",        64'(bus_if.rex_out),    64'h40);
        check("rst_rex_needed", 64'(bus_if.rex_needed), 64'd0);
        check("rst_done_len",   64'(bus_if.done_len),   64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        req(2'd1, 0, 4'd0, 1, 0, 1, 4'd1, 0, 4'd0, 2'd0, 0, 32'd0, 64'd0, 4'd0);
        expect_bytes(1, 112'hC1);
        fire("reg_reg", 0, 8'h40, 1);

        req(2'd1, 0, 4'd9, 0, 0, 1, 4'd4, 0, 4'd0, 2'd0, 1, 32'd8, 64'd0, 4'd0);
`ifdef OPD_ENC_SHORT_DISP_EN
        expect_bytes(3, 112'h08244C);
        fire("rsp_disp8", 0, 8'h44, 3);
`else
        expect_bytes(6, 112'h00000008248C);
        fire("rsp_disp32", 0, 8'h44, 6);
`endif

        toggle_en = 1'b1;
        req(2'd1, 0, 4'd2, 0, 0, 1, 4'd3, 1, 4'd6, 2'd2, 1, 32'h12345678, 64'h7F, 4'd1);
        expect_bytes(7, 112'h7F12345678B394);
        fire("sib_imm_toggle", 0, 8'h40, 7);
        toggle_en = 1'b0;

        req(2'd1, 0, 4'd0, 0, 0, 1, 4'd5, 0, 4'd0, 2'd0, 0, 32'd0, 64'd0, 4'd0);
`ifdef OPD_ENC_SHORT_DISP_EN
        expect_bytes(2, 112'h0045);
        fire("rbp_nodisp", 0, 8'h40, 2);
`else
        expect_bytes(5, 112'h0000000085);
        fire("rbp_nodisp", 0, 8'h40, 5);
`endif

        req(2'd1, 0, 4'd0, 0, 1, 0, 4'd0, 0, 4'd0, 2'd0, 1, 32'hFFFFFFF0, 64'd0, 4'd0);
        expect_bytes(5, 112'hFFFFFFF005);
        fire("rip_rel", 0, 8'h40, 5);

        req(2'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 2'd0, 0, 32'd0, 64'd0, 4'd0);
        fire("zero_byte", 0, 8'h40, 0);

        req(2'd0, 1, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 2'd0, 0, 32'd0, 64'h1234, 4'd2);
        expect_bytes(2, 112'h1234);
        fire("imm16_w", 0, 8'h48, 2);

        req(2'd3, 0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 2'd0, 1, 32'hFFFFFFFB, 64'd0, 4'd0);
        expect_bytes(1, 112'hFB);
        fire("rel8", 0, 8'h40, 1);

        req(2'd2, 0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 2'd0, 1, 32'h100, 64'hDEADBEEF, 4'd4);
        expect_bytes(8, 112'hDEADBEEF00000100);
        fire("rel32_imm32", 0, 8'h40, 8);

        req(2'd1, 0, 4'd0, 0, 0, 0, 4'd0, 1, 4'd8, 2'd3, 1, 32'h10, 64'd0, 4'd0);
        expect_bytes(6, 112'h00000010C504);
        fire("no_base", 0, 8'h42, 6);

        req(2'd1, 0, 4'd15, 0, 0, 1, 4'd12, 1, 4'd13, 2'd0, 0, 32'd0, 64'd0, 4'd0);
        expect_bytes(2, 112'h2C3C);
        fire("r12_r13", 0, 8'h47, 2);

        req(2'd1, 1, 4'd0, 0, 0, 0, 4'd0, 1, 4'd8, 2'd3, 1, 32'h10, 64'h0123456789ABCDEF, 4'd8);
        expect_bytes(14, 112'h0123456789ABCDEF00000010C504);
        fire("max_len", 0, 8'h4A, 14);

        req(2'd1, 0, 4'd0, 0, 0, 1, 4'd0, 1, 4'd4, 2'd0, 0, 32'd0, 64'd0, 4'd0);
        fire("err_index_rsp", 1, 8'h40, 0);
        req(2'd3, 0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 2'd0, 1, 32'd200, 64'd0, 4'd0);
        fire("err_rel8_range", 1, 8'h40, 0);
        req(2'd0, 0, 4'd0, 0, 0, 0, 4'd0, 0, 4'd0, 2'd0, 0, 32'd0, 64'h55, 4'd3);
        fire("err_imm3", 1, 8'h40, 0);
        req(2'd1, 0, 4'd0, 1, 1, 1, 4'd0, 0, 4'd0, 2'd0, 0, 32'd0, 64'd0, 4'd0);
        fire("err_rip_reg", 1, 8'h40, 0);

        req(2'd1, 0, 4'd2, 0, 0, 1, 4'd3, 1, 4'd6, 2'd2, 1, 32'h12345678, 64'h7F, 4'd1);
        expect_bytes(7, 112'h7F12345678B394);
        accept("mid_reset");
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(posedge clk);
            if (exp_q.size() <= 5) ok = 1'b1;
        end
        check("mid_reset_two_bytes", 64'(ok), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_reset_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("mid_reset_in_ready",  64'(bus_if.in_ready),  64'd1);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            check("mid_reset_no_done", 64'(bus_if.done), 64'd0);
        end
        @(posedge clk);
        #1;

        req(2'd1, 0, 4'd0, 1, 0, 1, 4'd1, 0, 4'd0, 2'd0, 0, 32'd0, 64'd0, 4'd0);
        expect_bytes(1, 112'hC1);
        fire("after_reset", 0, 8'h40, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
